// File: rtl/external_io_ctrl.sv
// -----------------------------------------------------------------------------
// external_io_ctrl
//
// Board-side I/O block for the shapool core array. It holds two mode-0 SPI
// slaves and a small job-control FSM.
//   * SPI0 loads the job configuration (JOB_CONFIG_WIDTH bits, MSB first).
//   * SPI1 loads the device configuration (DEVICE_CONFIG_WIDTH bits). Once a
//     core reports success, SPI1 becomes a readout port for
//     {result, match_flags}.
// All SPI pins are asynchronous to clk and pass through SYNC_STAGES flops.
// Edges are detected on the synchronised copies. Frames are shifted into a
// private register and copied to the visible output only when the bit count
// is exact, so the outputs never show a partial frame.
//
// Ports
//   clk, reset           system clock, synchronous active-high reset
//   sck0/sdi0/cs0_n      SPI0 (job config) clock, data, active-low select
//   sck1/sdi1/cs1_n      SPI1 (device config / readout) clock, data, select
//   sdo1                 SPI1 readout data, MSB first, 0 while deselected
//   device_config        committed device configuration
//   job_config           committed job configuration
//   core_reset           1 = hold the shapool cores in reset
//   shapool_match_flags  per-core match flags (latched on success)
//   shapool_result       winning nonce (latched on success)
//   shapool_success      level, a core has matched
//   ready                1 = result latched and readable on SPI1
//   frame_error          1-cycle pulse, a frame had the wrong bit count
//   o_dbg_state          current FSM state (0 IDLE, 1 RUN, 2 DONE)
// -----------------------------------------------------------------------------
module external_io_ctrl #(
    parameter int JOB_CONFIG_WIDTH    = 352,
    parameter int DEVICE_CONFIG_WIDTH = 8,
    parameter int RESULT_WIDTH        = 32,
    parameter int N_FLAGS             = 8,
    parameter int SYNC_STAGES         = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sck0,
    input  logic                           sdi0,
    input  logic                           cs0_n,
    input  logic                           sck1,
    input  logic                           sdi1,
    input  logic                           cs1_n,
    output logic                           sdo1,
    output logic [DEVICE_CONFIG_WIDTH-1:0] device_config,
    output logic [JOB_CONFIG_WIDTH-1:0]    job_config,
    output logic                           core_reset,
    input  logic [N_FLAGS-1:0]             shapool_match_flags,
    input  logic [RESULT_WIDTH-1:0]        shapool_result,
    input  logic                           shapool_success,
    output logic                           ready,
    output logic                           frame_error,
    output logic [1:0]                     o_dbg_state
);

    localparam int RD_W   = RESULT_WIDTH + N_FLAGS;
    localparam int CNT0_W = $clog2(JOB_CONFIG_WIDTH + 2);
    localparam int CNT1_W = $clog2(DEVICE_CONFIG_WIDTH + 2);
    localparam int RDC_W  = $clog2(RD_W + 1);

    localparam logic [CNT0_W-1:0] CNT0_FULL = CNT0_W'(JOB_CONFIG_WIDTH);
    localparam logic [CNT0_W-1:0] CNT0_SAT  = CNT0_W'(JOB_CONFIG_WIDTH + 1);
    localparam logic [CNT1_W-1:0] CNT1_FULL = CNT1_W'(DEVICE_CONFIG_WIDTH);
    localparam logic [CNT1_W-1:0] CNT1_SAT  = CNT1_W'(DEVICE_CONFIG_WIDTH + 1);
    localparam logic [RDC_W-1:0]  RDC_FULL  = RDC_W'(RD_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // ---------------------------------------------------------------------
    // Input synchronisers. Everything resets to 0, including the select
    // lines: a select that is already low when reset is released then shows
    // no falling edge, so the tail of an interrupted frame is ignored.
    // ---------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sck0_sync, r_sdi0_sync, r_cs0_sync;
    logic [SYNC_STAGES-1:0] r_sck1_sync, r_sdi1_sync, r_cs1_sync;
    logic                   r_sck0_q, r_cs0_q, r_sck1_q, r_cs1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sck0_sync <= '0;
            r_sdi0_sync <= '0;
            r_cs0_sync  <= '0;
            r_sck1_sync <= '0;
            r_sdi1_sync <= '0;
            r_cs1_sync  <= '0;
            r_sck0_q    <= 1'b0;
            r_cs0_q     <= 1'b0;
            r_sck1_q    <= 1'b0;
            r_cs1_q     <= 1'b0;
        end else begin
            r_sck0_sync <= {r_sck0_sync[SYNC_STAGES-2:0], sck0};
            r_sdi0_sync <= {r_sdi0_sync[SYNC_STAGES-2:0], sdi0};
            r_cs0_sync  <= {r_cs0_sync[SYNC_STAGES-2:0], cs0_n};
            r_sck1_sync <= {r_sck1_sync[SYNC_STAGES-2:0], sck1};
            r_sdi1_sync <= {r_sdi1_sync[SYNC_STAGES-2:0], sdi1};
            r_cs1_sync  <= {r_cs1_sync[SYNC_STAGES-2:0], cs1_n};
            r_sck0_q    <= r_sck0_sync[SYNC_STAGES-1];
            r_cs0_q     <= r_cs0_sync[SYNC_STAGES-1];
            r_sck1_q    <= r_sck1_sync[SYNC_STAGES-1];
            r_cs1_q     <= r_cs1_sync[SYNC_STAGES-1];
        end
    end

    logic w_sck0_s, w_sdi0_s, w_cs0_s, w_sck1_s, w_sdi1_s, w_cs1_s;
    logic w_cs0_fall, w_cs0_rise, w_sck0_rise;
    logic w_cs1_fall, w_cs1_rise, w_sck1_rise, w_sck1_fall;

    assign w_sck0_s    = r_sck0_sync[SYNC_STAGES-1];
    assign w_sdi0_s    = r_sdi0_sync[SYNC_STAGES-1];
    assign w_cs0_s     = r_cs0_sync[SYNC_STAGES-1];
    assign w_sck1_s    = r_sck1_sync[SYNC_STAGES-1];
    assign w_sdi1_s    = r_sdi1_sync[SYNC_STAGES-1];
    assign w_cs1_s     = r_cs1_sync[SYNC_STAGES-1];

    assign w_cs0_fall  = r_cs0_q & ~w_cs0_s;
    assign w_cs0_rise  = ~r_cs0_q & w_cs0_s;
    assign w_sck0_rise = ~r_sck0_q & w_sck0_s & ~w_cs0_s;
    assign w_cs1_fall  = r_cs1_q & ~w_cs1_s;
    assign w_cs1_rise  = ~r_cs1_q & w_cs1_s;
    assign w_sck1_rise = ~r_sck1_q & w_sck1_s & ~w_cs1_s;
    assign w_sck1_fall = r_sck1_q & ~w_sck1_s & ~w_cs1_s;

    // ---------------------------------------------------------------------
    // SPI0: job configuration receiver. r_act0 marks a frame that began with
    // a real select falling edge since the last reset.
    // ---------------------------------------------------------------------
    logic                        r_act0;
    logic [CNT0_W-1:0]           r_cnt0;
    logic [JOB_CONFIG_WIDTH-1:0] r_shift0;
    logic [JOB_CONFIG_WIDTH-1:0] r_job_cfg;
    logic                        w_commit0, w_err0;

    assign w_commit0 = w_cs0_rise & r_act0 & (r_cnt0 == CNT0_FULL);
    assign w_err0    = w_cs0_rise & r_act0 & (r_cnt0 != CNT0_FULL);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_act0    <= 1'b0;
            r_cnt0    <= '0;
            r_shift0  <= '0;
            r_job_cfg <= '0;
        end else begin
            if (w_cs0_fall) begin
                r_act0 <= 1'b1;
                r_cnt0 <= '0;
            end else if (w_cs0_rise) begin
                r_act0 <= 1'b0;
            end else if (w_sck0_rise && r_act0) begin
                r_shift0 <= {r_shift0[JOB_CONFIG_WIDTH-2:0], w_sdi0_s};
                if (r_cnt0 != CNT0_SAT)
                    r_cnt0 <= r_cnt0 + CNT0_W'(1);
            end
            if (w_commit0)
                r_job_cfg <= r_shift0;
        end
    end

    // ---------------------------------------------------------------------
    // SPI1: device-config receiver, or result readout when the frame starts
    // in DONE. The mode is fixed at the select falling edge for the whole
    // frame. The readout register shifts on sck1 falling edges so the next
    // bit is stable before the master samples on the rising edge.
    // ---------------------------------------------------------------------
    logic                           r_act1, r_rd_mode;
    logic [CNT1_W-1:0]              r_cnt1;
    logic [DEVICE_CONFIG_WIDTH-1:0] r_shift1;
    logic [DEVICE_CONFIG_WIDTH-1:0] r_dev_cfg;
    logic [RD_W-1:0]                r_rd_sreg;
    logic [RDC_W-1:0]               r_rd_cnt;
    logic [RESULT_WIDTH-1:0]        r_result_q;
    logic [N_FLAGS-1:0]             r_flags_q;
    logic                           w_commit1, w_err1, w_rd_done;

    assign w_commit1 = w_cs1_rise & r_act1 & ~r_rd_mode & (r_cnt1 == CNT1_FULL);
    assign w_err1    = w_cs1_rise & r_act1 & ~r_rd_mode & (r_cnt1 != CNT1_FULL);
    assign w_rd_done = w_cs1_rise & r_act1 & r_rd_mode & (r_rd_cnt == RDC_FULL);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_act1    <= 1'b0;
            r_rd_mode <= 1'b0;
            r_cnt1    <= '0;
            r_shift1  <= '0;
            r_dev_cfg <= '0;
            r_rd_sreg <= '0;
            r_rd_cnt  <= '0;
        end else begin
            if (w_cs1_fall) begin
                r_act1    <= 1'b1;
                r_cnt1    <= '0;
                r_rd_cnt  <= '0;
                r_rd_mode <= (r_state == ST_DONE);
                if (r_state == ST_DONE)
                    r_rd_sreg <= {r_result_q, r_flags_q};
            end else if (w_cs1_rise) begin
                r_act1    <= 1'b0;
                r_rd_mode <= 1'b0;
            end else if (r_act1) begin
                if (w_sck1_rise) begin
                    if (r_rd_mode) begin
                        if (r_rd_cnt != RDC_FULL)
                            r_rd_cnt <= r_rd_cnt + RDC_W'(1);
                    end else begin
                        r_shift1 <= {r_shift1[DEVICE_CONFIG_WIDTH-2:0], w_sdi1_s};
                        if (r_cnt1 != CNT1_SAT)
                            r_cnt1 <= r_cnt1 + CNT1_W'(1);
                    end
                end
                if (w_sck1_fall && r_rd_mode)
                    r_rd_sreg <= {r_rd_sreg[RD_W-2:0], 1'b0};
            end
            if (w_commit1)
                r_dev_cfg <= r_shift1;
        end
    end

    // ---------------------------------------------------------------------
    // Loaded flags, result latch and frame-error pulse. dev_loaded is sticky
    // until reset; job_loaded is consumed by a complete readout. A job commit
    // landing in the same cycle as the readout exit keeps the new job.
    // ---------------------------------------------------------------------
    logic r_job_loaded, r_dev_loaded, r_frame_error;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_job_loaded  <= 1'b0;
            r_dev_loaded  <= 1'b0;
            r_result_q    <= '0;
            r_flags_q     <= '0;
            r_frame_error <= 1'b0;
        end else begin
            r_frame_error <= w_err0 | w_err1;
            if (w_commit1)
                r_dev_loaded <= 1'b1;
            if (w_rd_done)
                r_job_loaded <= 1'b0;
            if (w_commit0)
                r_job_loaded <= 1'b1;
            if (r_state == ST_RUN && shapool_success) begin
                r_result_q <= shapool_result;
                r_flags_q  <= shapool_match_flags;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Job-control FSM. A new job arriving in RUN drops to IDLE for one cycle,
    // which gives the cores a one-cycle reset pulse before restarting.
    // Success takes priority over a simultaneous job commit.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_job_loaded && r_dev_loaded && w_cs0_s && w_cs1_s)
                    w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (shapool_success)
                    w_state_next = ST_DONE;
                else if (w_commit0)
                    w_state_next = ST_IDLE;
            end
            ST_DONE: begin
                if (w_rd_done)
                    w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign core_reset    = (r_state != ST_RUN);
    assign ready         = (r_state == ST_DONE);
    assign sdo1          = ~w_cs1_s & r_rd_mode & r_rd_sreg[RD_W-1];
    assign job_config    = r_job_cfg;
    assign device_config = r_dev_cfg;
    assign frame_error   = r_frame_error;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_external_io_ctrl.sv
// -----------------------------------------------------------------------------
// tb_external_io_ctrl
// Directed bench for external_io_ctrl: SPI masters driven at a half-period of
// 5 clk, with outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_external_io_ctrl;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         sck0 = 1'b0, sdi0 = 1'b0, cs0_n = 1'b1;
    logic         sck1 = 1'b0, sdi1 = 1'b0, cs1_n = 1'b1;
    logic         sdo1;
    logic [7:0]   device_config;
    logic [351:0] job_config;
    logic         core_reset;
    logic [7:0]   shapool_match_flags = 8'h00;
    logic [31:0]  shapool_result = 32'h0;
    logic         shapool_success = 1'b0;
    logic         ready;
    logic         frame_error;
    logic [1:0]   o_dbg_state;

    int n_checks = 0;
    int n_err    = 0;
    int fe_cycles = 0;

    external_io_ctrl dut (
        .clk                 (clk),
        .reset               (reset),
        .sck0                (sck0),
        .sdi0                (sdi0),
        .cs0_n               (cs0_n),
        .sck1                (sck1),
        .sdi1                (sdi1),
        .cs1_n               (cs1_n),
        .sdo1                (sdo1),
        .device_config       (device_config),
        .job_config          (job_config),
        .core_reset          (core_reset),
        .shapool_match_flags (shapool_match_flags),
        .shapool_result      (shapool_result),
        .shapool_success     (shapool_success),
        .ready               (ready),
        .frame_error         (frame_error),
        .o_dbg_state         (o_dbg_state)
    );

    always #5 clk = ~clk;

    // Number of clock cycles frame_error has been high.
    always @(posedge clk)
        if (frame_error === 1'b1)
            fe_cycles <= fe_cycles + 1;

    task automatic check(input string tag, input logic [351:0] got, input logic [351:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic spi_half();
        repeat (5) @(negedge clk);
    endtask

    task automatic set_pin(input int port, input int which, input logic v);
        if (port == 0) begin
            if (which == 0) cs0_n = v; else if (which == 1) sck0 = v; else sdi0 = v;
        end else begin
            if (which == 0) cs1_n = v; else if (which == 1) sck1 = v; else sdi1 = v;
        end
    endtask

    // Sends data[nbits-1:0] MSB first; leaves the select high at return.
    task automatic spi_frame(input int port, input logic [351:0] data, input int nbits);
        set_pin(port, 0, 1'b0);
        spi_half();
        for (int i = 0; i < nbits; i++) begin
            set_pin(port, 2, data[nbits-1-i]);
            spi_half();
            set_pin(port, 1, 1'b1);
            spi_half();
            set_pin(port, 1, 1'b0);
        end
        spi_half();
        set_pin(port, 0, 1'b1);
    endtask

    // Samples sdo1 just before each sck1 rising edge.
    task automatic spi1_read(input int nbits, output logic [39:0] got);
        got = '0;
        cs1_n = 1'b0;
        spi_half();
        for (int i = 0; i < nbits; i++) begin
            got = {got[38:0], sdo1};
            sck1 = 1'b1;
            spi_half();
            sck1 = 1'b0;
            spi_half();
        end
        cs1_n = 1'b1;
    endtask

    logic [351:0] job_a, job_b, job_c;
    logic [39:0]  rd;
    int           lat, hi_cnt, fe_base;

    initial begin
        job_a = {32'h8000_0001, {10{32'h1234_5678}}};
        job_b = {11{32'hCAFE_F00D}};
        job_c = {11{32'h0F1E_2D3D}};

        // 1: reset held 5 clk
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_core_reset", 352'(core_reset), 352'(1'b1));
        check("rst_ready", 352'(ready), 352'(1'b0));
        check("rst_job_config", job_config, '0);
        check("rst_device_config", 352'(device_config), '0);
        check("rst_sdo1", 352'(sdo1), '0);
        check("rst_frame_error", 352'(frame_error), '0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // 2: full SPI0 frame then SPI1 8'hAA; RUN 4 clk after cs1_n rises
        spi_frame(0, job_a, 352);
        repeat (10) @(negedge clk);
        check("job_a_commit", job_config, job_a);
        check("idle_wait_dev", 352'(core_reset), 352'(1'b1));
        spi_frame(1, 352'(8'hAA), 8);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (core_reset === 1'b0 && lat == 0) lat = n;
        end
        check("run_latency", 352'(lat), 352'(4));
        check("dev_aa_commit", 352'(device_config), 352'(8'hAA));
        check("state_run", 352'(o_dbg_state), 352'(S_RUN));

        // 3: short and long SPI1 frames are rejected with one pulse each
        fe_base = fe_cycles;
        spi_frame(1, 352'(7'h55), 7);
        repeat (10) @(negedge clk);
        check("short_fe_pulse", 352'(fe_cycles - fe_base), 352'(1));
        check("short_dev_kept", 352'(device_config), 352'(8'hAA));
        fe_base = fe_cycles;
        spi_frame(1, 352'(9'h1FF), 9);
        repeat (10) @(negedge clk);
        check("long_fe_pulse", 352'(fe_cycles - fe_base), 352'(1));
        check("long_dev_kept", 352'(device_config), 352'(8'hAA));
        spi_frame(1, 352'(8'h3C), 8);
        repeat (10) @(negedge clk);
        check("dev_3c_in_run", 352'(device_config), 352'(8'h3C));
        check("run_kept", 352'(core_reset), 352'(1'b0));

        // 5: new job in RUN -> exactly one core_reset cycle
        spi_frame(0, job_b, 352);
        hi_cnt = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (core_reset === 1'b1) hi_cnt++;
        end
        check("rejob_pulse_len", 352'(hi_cnt), 352'(1));
        check("job_b_commit", job_config, job_b);
        check("rejob_state_run", 352'(o_dbg_state), 352'(S_RUN));

        // 4: success, latch, short read, full read, exit
        shapool_result = 32'hEEDDCCBB;
        shapool_match_flags = 8'hAA;
        shapool_success = 1'b1;
        repeat (2) @(negedge clk);
        check("done_ready", 352'(ready), 352'(1'b1));
        check("done_core_reset", 352'(core_reset), 352'(1'b1));
        check("state_done", 352'(o_dbg_state), 352'(S_DONE));
        shapool_success = 1'b0;
        shapool_result = 32'h1234_5678;
        shapool_match_flags = 8'h0F;
        fe_base = fe_cycles;
        spi1_read(20, rd);
        repeat (10) @(negedge clk);
        check("short_read_bits", 352'(rd[19:0]), 352'(20'hEEDDC));
        check("short_read_ready", 352'(ready), 352'(1'b1));
        spi1_read(40, rd);
        check("readout", 352'(rd), 352'(40'hEEDDCCBBAA));
        repeat (10) @(negedge clk);
        check("exit_ready", 352'(ready), 352'(1'b0));
        check("exit_core_reset", 352'(core_reset), 352'(1'b1));
        check("exit_state_idle", 352'(o_dbg_state), 352'(S_IDLE));
        check("exit_sdo1", 352'(sdo1), '0);
        check("read_no_fe", 352'(fe_cycles - fe_base), '0);

        // success outside RUN is ignored
        shapool_success = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_success_ignored", 352'(ready), 352'(1'b0));
        shapool_success = 1'b0;

        // 6: reset at SPI0 bit 100 aborts the frame quietly
        fe_base = fe_cycles;
        cs0_n = 1'b0;
        spi_half();
        for (int i = 0; i < 352; i++) begin
            if (i == 100) begin
                reset = 1'b1;
                repeat (5) @(negedge clk);
                reset = 1'b0;
            end
            sdi0 = job_b[351-i];
            spi_half();
            sck0 = 1'b1;
            spi_half();
            sck0 = 1'b0;
        end
        spi_half();
        cs0_n = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_no_commit", job_config, '0);
        check("abort_no_fe", 352'(fe_cycles - fe_base), '0);
        check("abort_dev_cleared", 352'(device_config), '0);
        spi_frame(0, job_c, 352);
        repeat (10) @(negedge clk);
        check("job_c_commit", job_config, job_c);
        check("job_c_wait_dev", 352'(core_reset), 352'(1'b1));
        spi_frame(1, 352'(8'h5A), 8);
        repeat (10) @(negedge clk);
        check("dev_5a_commit", 352'(device_config), 352'(8'h5A));
        check("job_c_run", 352'(core_reset), 352'(1'b0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
